// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM states, RV32I load/store funct3 codes and request legality check
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP, ERR} lsu_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic req_err(input logic is_store, input logic [2:0] op, input logic [1:0] off);
    return (is_store ? op > F3_W : (op == 3'b011 || op[2:1] == 2'b11)) ||
           (op[1:0] == 2'b01 && off[0]) || (op == F3_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-stage request/response bus; master = requester, slave = LSU
interface load_store_unit_if #(parameter int ADDR_W = 10);
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_is_store;
  logic [2:0]        lsu_op;
  logic [ADDR_W+1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic              lsu_rsp_valid;
  logic [31:0]       lsu_rdata;
  logic              lsu_err;
  modport master (output lsu_req_valid, lsu_is_store, lsu_op, lsu_addr, lsu_wdata,
                  input lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_err);
  modport slave (input lsu_req_valid, lsu_is_store, lsu_op, lsu_addr, lsu_wdata,
                 output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_err);
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend (load_o) and lane merge into read word (store_o)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  logic [31:0] data;
  always_comb begin
    b = rdata_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o = op_i == F3_B  ? {{24{b[7]}}, b} :
             op_i == F3_BU ? {24'b0, b} :
             op_i == F3_H  ? {{16{h[15]}}, h} :
             op_i == F3_HU ? {16'b0, h} : rdata_i;
    mask = op_i == F3_B ? 32'hFF << {off_i, 3'b000} :
           op_i == F3_H ? (off_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : '1;
    data = op_i == F3_B ? {4{wdata_i[7:0]}} : op_i == F3_H ? {2{wdata_i[15:0]}} : wdata_i;
    store_o = (rdata_i & ~mask) | (data & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RV32I load/store initiator (lsu bus in, d_* word memory out)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_LEN = 32
) (
  input  logic                d_clk,
  input  logic                d_rst_n,
  load_store_unit_if.slave    lsu,
  output logic [ADDR_W-1:0]   d_addr,
  output logic [DATA_LEN-1:0] d_w_data,
  output logic                d_rw_en,
  output logic                d_cs,
  input  logic [DATA_LEN-1:0] d_r_data
);
  lsu_state_e          state_q, state_d;
  logic [2:0]          op_q;
  logic                st_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [DATA_LEN-1:0] rdata_q;
  logic [31:0]         load_val;
  logic [31:0]         store_word;
  logic                accept;
  assign accept = lsu.lsu_req_valid && state_q == IDLE;
  lsu_lane_align u_align (
    .op_i   (op_q),
    .off_i  (addr_q[1:0]),
    .rdata_i(d_r_data),
    .wdata_i(wdata_q),
    .load_o (load_val),
    .store_o(store_word)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = !accept ? IDLE :
                      req_err(lsu.lsu_is_store, lsu.lsu_op, lsu.lsu_addr[1:0]) ? ERR :
                      (lsu.lsu_is_store && lsu.lsu_op == F3_W) ? WR : RD;
      RD:      state_d = CAP;
      CAP:     state_d = st_q ? WR : RSP;
      WR:      state_d = RSP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= lsu.lsu_op;
        st_q    <= lsu.lsu_is_store;
        addr_q  <= lsu.lsu_addr;
        wdata_q <= lsu.lsu_wdata;
      end
      // read word is valid only in CAP: store merges into wdata_q, load captures result
      if (state_q == CAP && st_q) wdata_q <= store_word;
      if (state_q == CAP && !st_q) rdata_q <= load_val;
    end
  end
  assign d_cs              = state_q == RD || state_q == WR;
  assign d_rw_en           = state_q == WR;
  assign d_w_data          = d_rw_en ? wdata_q : '0;
  assign d_addr            = addr_q[ADDR_W+1:2];
  assign lsu.lsu_req_ready = state_q == IDLE;
  assign lsu.lsu_rsp_valid = state_q == RSP || state_q == ERR;
  assign lsu.lsu_err       = state_q == ERR;
  assign lsu.lsu_rdata     = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench with clocked word-memory model
module tb_load_store_unit;
  logic        d_clk = 0;
  logic        d_rst_n = 0;
  logic [9:0]  d_addr;
  logic [31:0] d_w_data;
  logic        d_rw_en;
  logic        d_cs;
  logic [31:0] d_r_data;
  logic [31:0] mem [0:1023];
  logic        pre_we = 0;
  logic [9:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  int          errors = 0;
  int          checks = 0;
  load_store_unit_if #(.ADDR_W(10)) bus ();
  load_store_unit #(.ADDR_W(10), .DATA_LEN(32)) dut (
    .d_clk   (d_clk),
    .d_rst_n (d_rst_n),
    .lsu     (bus),
    .d_addr  (d_addr),
    .d_w_data(d_w_data),
    .d_rw_en (d_rw_en),
    .d_cs    (d_cs),
    .d_r_data(d_r_data)
  );
  always #5 d_clk = ~d_clk;
  always @(posedge d_clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (d_cs && d_rw_en) mem[d_addr] <= d_w_data;
    if (d_cs && !d_rw_en) d_r_data <= mem[d_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input string tag, input logic st, input logic [2:0] op, input logic [11:0] a,
                     input logic [31:0] wd, input int lat, input logic e, input logic [31:0] rd, input int cs);
    int got_lat;
    int n_cs;
    got_lat = 0;
    n_cs = 0;
    @(negedge d_clk);
    bus.lsu_req_valid = 1;
    bus.lsu_is_store = st;
    bus.lsu_op = op;
    bus.lsu_addr = a;
    bus.lsu_wdata = wd;
    chk({tag, ".ready"}, 32'(bus.lsu_req_ready), 32'd1);
    @(posedge d_clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge d_clk);
      if (k == 1) bus.lsu_req_valid = 0;
      n_cs += int'(d_cs);
      if (bus.lsu_rsp_valid) begin
        got_lat = k;
        break;
      end
    end
    chk({tag, ".lat"}, 32'(got_lat), 32'(lat));
    chk({tag, ".err"}, 32'(bus.lsu_err), 32'(e));
    chk({tag, ".rdata"}, bus.lsu_rdata, rd);
    chk({tag, ".cs_cycles"}, 32'(n_cs), 32'(cs));
  endtask
  initial begin
    bus.lsu_req_valid = 0;
    bus.lsu_is_store = 0;
    bus.lsu_op = 0;
    bus.lsu_addr = 0;
    bus.lsu_wdata = 0;
    pre_we = 1;
    pre_a = 10'd3;
    pre_d = 32'h8765_80F0;
    @(negedge d_clk);
    pre_we = 0;
    @(negedge d_clk);
    chk("rst.ready", 32'(bus.lsu_req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus.lsu_rsp_valid), 32'd0);
    chk("rst.err", 32'(bus.lsu_err), 32'd0);
    chk("rst.cs", 32'(d_cs), 32'd0);
    chk("rst.rw_en", 32'(d_rw_en), 32'd0);
    chk("rst.rdata", bus.lsu_rdata, 32'd0);
    chk("rst.d_addr", 32'(d_addr), 32'd0);
    chk("rst.w_data", d_w_data, 32'd0);
    d_rst_n = 1;
    req("lb",  0, 3'b000, 12'h00C, 0, 3, 0, 32'hFFFF_FFF0, 1);
    req("lbu", 0, 3'b100, 12'h00E, 0, 3, 0, 32'h0000_0065, 1);
    req("lh",  0, 3'b001, 12'h00C, 0, 3, 0, 32'hFFFF_80F0, 1);
    req("lhu", 0, 3'b101, 12'h00E, 0, 3, 0, 32'h0000_8765, 1);
    req("sb",  1, 3'b000, 12'h00D, 32'h0000_00AB, 4, 0, 32'h0000_8765, 2);
    chk("sb.mem3", mem[3], 32'h8765_ABF0);
    req("sw",  1, 3'b010, 12'h010, 32'hDEAD_BEEF, 2, 0, 32'h0000_8765, 1);
    chk("sw.mem4", mem[4], 32'hDEAD_BEEF);
    req("lw",  0, 3'b010, 12'h010, 0, 3, 0, 32'hDEAD_BEEF, 1);
    req("lh_mis", 0, 3'b001, 12'h00D, 0, 1, 1, 32'hDEAD_BEEF, 0);
    req("st_op3", 1, 3'b011, 12'h00C, 32'h1111_1111, 1, 1, 32'hDEAD_BEEF, 0);
    req("ld_op7", 0, 3'b111, 12'h00C, 0, 1, 1, 32'hDEAD_BEEF, 0);
    req("sw_mis", 1, 3'b010, 12'h00E, 32'h2222_2222, 1, 1, 32'hDEAD_BEEF, 0);
    chk("err.mem3", mem[3], 32'h8765_ABF0);
    req("sh",  1, 3'b001, 12'h00C, 32'hCAFE_1234, 4, 0, 32'hDEAD_BEEF, 2);
    chk("sh.mem3", mem[3], 32'h8765_1234);
    req("lh_hi", 0, 3'b001, 12'h00E, 0, 3, 0, 32'hFFFF_8765, 1);
    @(negedge d_clk);
    bus.lsu_req_valid = 1;
    bus.lsu_is_store = 1;
    bus.lsu_op = 3'b001;
    bus.lsu_addr = 12'h010;
    bus.lsu_wdata = 32'h0000_5555;
    @(posedge d_clk);
    @(negedge d_clk);
    bus.lsu_req_valid = 0;
    @(negedge d_clk);
    @(negedge d_clk);
    chk("rst_wr.cs_before", 32'(d_cs), 32'd1);
    chk("rst_wr.rw_before", 32'(d_rw_en), 32'd1);
    d_rst_n = 0;
    #1;
    chk("rst_wr.cs_now", 32'(d_cs), 32'd0);
    chk("rst_wr.ready", 32'(bus.lsu_req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge d_clk);
      chk("rst_wr.no_rsp", 32'(bus.lsu_rsp_valid), 32'd0);
    end
    d_rst_n = 1;
    @(negedge d_clk);
    chk("rst_wr.mem4", mem[4], 32'hDEAD_BEEF);
    chk("rst_wr.no_rsp_after", 32'(bus.lsu_rsp_valid), 32'd0);
    bus.lsu_req_valid = 1;
    bus.lsu_is_store = 0;
    bus.lsu_op = 3'b010;
    bus.lsu_addr = 12'h010;
    bus.lsu_wdata = 0;
    @(posedge d_clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge d_clk);
      chk("b2b.ready_low1", 32'(bus.lsu_req_ready), 32'd0);
      chk("b2b.rsp1", 32'(bus.lsu_rsp_valid), 32'(k == 3));
    end
    chk("b2b.rdata1", bus.lsu_rdata, 32'hDEAD_BEEF);
    bus.lsu_addr = 12'h00C;
    @(negedge d_clk);
    chk("b2b.ready_idle", 32'(bus.lsu_req_ready), 32'd1);
    @(posedge d_clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge d_clk);
      if (k == 1) bus.lsu_req_valid = 0;
      chk("b2b.ready_low2", 32'(bus.lsu_req_ready), 32'd0);
      chk("b2b.rsp2", 32'(bus.lsu_rsp_valid), 32'(k == 3));
    end
    chk("b2b.rdata2", bus.lsu_rdata, 32'h8765_1234);
    @(negedge d_clk);
    chk("b2b.done_idle", 32'(bus.lsu_req_ready), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
